// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: captures the memory-stage result and presents one registered
// writeback beat plus the MEM/WB forwarding source. Optional counters: MEM_WB_PERF_EN.
module mem_wb_register #(
  parameter int DATA_W = 64,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] read_data,
  input  logic [REG_W-1:0]  rd,
  input  logic              RegWrite,
  input  logic              MemtoReg,
  input  logic              MemRead,
  input  logic              MemWrite,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_RegWrite,
  output logic              fwd_en,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`ifdef MEM_WB_PERF_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores
`endif
);

  localparam logic [REG_W-1:0] XZR_IDX = REG_W'(31);

  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic [REG_W-1:0]  rd_r;
  logic              regwrite_r;

  logic              valid_nxt_s;
  logic [DATA_W-1:0] data_nxt_s;
  logic [REG_W-1:0]  rd_nxt_s;
  logic              regwrite_nxt_s;
  logic              capture_s;

  // Next-state select: flush beats stall beats capture (reset is applied in the register)
  always_comb begin
    valid_nxt_s    = valid_r;
    data_nxt_s     = data_r;
    rd_nxt_s       = rd_r;
    regwrite_nxt_s = regwrite_r;
    capture_s      = 1'b0;
    if (flush) begin
      valid_nxt_s    = 1'b0;
      data_nxt_s     = {DATA_W{1'b0}};
      rd_nxt_s       = {REG_W{1'b0}};
      regwrite_nxt_s = 1'b0;
    end else if (stall) begin
      valid_nxt_s    = valid_r;
      data_nxt_s     = data_r;
      rd_nxt_s       = rd_r;
      regwrite_nxt_s = regwrite_r;
    end else begin
      capture_s      = 1'b1;
      valid_nxt_s    = in_valid;
      data_nxt_s     = MemtoReg ? read_data : alu_result;
      rd_nxt_s       = rd;
      // XZR and bubbles still carry data/rd but must never write the register file
      regwrite_nxt_s = in_valid & RegWrite & (rd != XZR_IDX);
    end
  end

  // Writeback beat register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r    <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      rd_r       <= {REG_W{1'b0}};
      regwrite_r <= 1'b0;
    end else begin
      valid_r    <= valid_nxt_s;
      data_r     <= data_nxt_s;
      rd_r       <= rd_nxt_s;
      regwrite_r <= regwrite_nxt_s;
    end
  end

  assign wb_valid    = valid_r;
  assign wb_data     = data_r;
  assign wb_rd       = rd_r;
  assign wb_RegWrite = regwrite_r;
  assign fwd_en      = regwrite_r;
  assign fwd_rd      = rd_r;
  assign fwd_data    = data_r;

`ifdef MEM_WB_PERF_EN
  logic [31:0] retired_r;
  logic [31:0] loads_r;
  logic [31:0] stores_r;

  // Event counters advance only on capture edges and wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_r <= 32'd0;
      loads_r   <= 32'd0;
      stores_r  <= 32'd0;
    end else if (capture_s) begin
      retired_r <= retired_r + {31'd0, in_valid};
      loads_r   <= loads_r + {31'd0, in_valid & MemRead};
      stores_r  <= stores_r + {31'd0, in_valid & MemWrite};
    end else begin
      retired_r <= retired_r;
      loads_r   <= loads_r;
      stores_r  <= stores_r;
    end
  end

  assign perf_retired = retired_r;
  assign perf_loads   = loads_r;
  assign perf_stores  = stores_r;
`else
  logic unused_s;
  assign unused_s = ^{MemRead, MemWrite, capture_s};
`endif

endmodule

// File: tb/tb_mem_wb_register.sv
// Directed table-driven bench for mem_wb_register; counter checks follow MEM_WB_PERF_EN.
module tb_mem_wb_register;

  logic        clock = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [63:0] alu_result, read_data;
  logic [4:0]  rd;
  logic        RegWrite, MemtoReg, MemRead, MemWrite;
  logic        wb_valid, wb_RegWrite, fwd_en;
  logic [63:0] wb_data, fwd_data;
  logic [4:0]  wb_rd, fwd_rd;
`ifdef MEM_WB_PERF_EN
  logic [31:0] perf_retired, perf_loads, perf_stores;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_wb_register #(.DATA_W(64), .REG_W(5)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .alu_result(alu_result), .read_data(read_data), .rd(rd), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`ifdef MEM_WB_PERF_EN
    , .perf_retired(perf_retired), .perf_loads(perf_loads), .perf_stores(perf_stores)
`endif
  );

  typedef struct {
    logic        rst, stl, fls, iv;
    logic [63:0] alu, rdat;
    logic [4:0]  rdi;
    logic        rw, m2r, mr, mw;
    logic        e_v;
    logic [63:0] e_data;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_ret, e_ld, e_st;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; flush = v.fls; in_valid = v.iv;
    alu_result = v.alu; read_data = v.rdat; rd = v.rdi;
    RegWrite = v.rw; MemtoReg = v.m2r; MemRead = v.mr; MemWrite = v.mw;
  endtask

  task automatic chk_beat(input string tag, input logic v, input logic [63:0] d,
                          input logic [4:0] r, input logic w);
    chk({tag, " wb_valid"}, {63'd0, wb_valid}, {63'd0, v});
    chk({tag, " wb_data"}, wb_data, d);
    chk({tag, " wb_rd"}, {59'd0, wb_rd}, {59'd0, r});
    chk({tag, " wb_RegWrite"}, {63'd0, wb_RegWrite}, {63'd0, w});
    chk({tag, " fwd_en"}, {63'd0, fwd_en}, {63'd0, w});
    chk({tag, " fwd_rd"}, {59'd0, fwd_rd}, {59'd0, r});
    chk({tag, " fwd_data"}, fwd_data, d);
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] ret,
                          input logic [31:0] ld, input logic [31:0] st);
`ifdef MEM_WB_PERF_EN
    chk({tag, " perf_retired"}, {32'd0, perf_retired}, {32'd0, ret});
    chk({tag, " perf_loads"}, {32'd0, perf_loads}, {32'd0, ld});
    chk({tag, " perf_stores"}, {32'd0, perf_stores}, {32'd0, st});
`else
    if (ret === 32'hFFFF_FFFF && ld === 32'hFFFF_FFFF && st === 32'hFFFF_FFFF)
      $display("[TB] %s counters not built", tag);
`endif
  endtask

  initial begin
    //          rst  stl  fls  iv   alu                     rdat                    rd     rw   m2r  mr   mw    e_v  e_data                  e_rd   e_rw  ret    ld     st
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b1,64'hFFFF_0000_1111_2222,64'h3333_4444_5555_6666,5'd9, 1'b1,1'b1,1'b1,1'b1, 1'b0,64'h0,                 5'd0, 1'b0, 32'd0,32'd0,32'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b1,64'hFFFF_0000_1111_2222,64'h3333_4444_5555_6666,5'd9, 1'b1,1'b1,1'b1,1'b1, 1'b0,64'h0,                 5'd0, 1'b0, 32'd0,32'd0,32'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_DEAD_BEEF,64'h0000_0000_0000_0BAD,5'd9, 1'b1,1'b0,1'b0,1'b0, 1'b1,64'h0000_0000_DEAD_BEEF,5'd9, 1'b1, 32'd1,32'd0,32'd0};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_0040,64'h1234_5678_9ABC_DEF0,5'd3, 1'b1,1'b1,1'b1,1'b0, 1'b1,64'h1234_5678_9ABC_DEF0,5'd3, 1'b1, 32'd2,32'd1,32'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_0055,64'h0000_0000_0000_0066,5'd31,1'b1,1'b0,1'b0,1'b0, 1'b1,64'h0000_0000_0000_0055,5'd31,1'b0, 32'd3,32'd1,32'd0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,64'h0000_0000_0000_0077,64'h0000_0000_0000_0088,5'd4, 1'b1,1'b0,1'b1,1'b0, 1'b0,64'h0000_0000_0000_0077,5'd4, 1'b0, 32'd3,32'd1,32'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_0100,64'h0000_0000_0000_0000,5'd2, 1'b0,1'b0,1'b0,1'b1, 1'b1,64'h0000_0000_0000_0100,5'd2, 1'b0, 32'd4,32'd1,32'd1};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b1,64'h0000_0000_0000_00AA,64'h0000_0000_0000_00BB,5'd6, 1'b1,1'b1,1'b1,1'b1, 1'b0,64'h0,                 5'd0, 1'b0, 32'd4,32'd1,32'd1};
    vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_5555,64'h0000_0000_0000_0000,5'd5, 1'b1,1'b0,1'b0,1'b0, 1'b1,64'h0000_0000_0000_5555,5'd5, 1'b1, 32'd5,32'd1,32'd1};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,64'h0000_0000_0000_7777,64'h0000_0000_0000_9999,5'd7, 1'b1,1'b0,1'b1,1'b0, 1'b1,64'h0000_0000_0000_5555,5'd5, 1'b1, 32'd5,32'd1,32'd1};
    vecs[10] = vecs[9];
    vecs[11] = vecs[9];
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_7777,64'h0000_0000_0000_9999,5'd7, 1'b1,1'b0,1'b1,1'b0, 1'b1,64'h0000_0000_0000_7777,5'd7, 1'b1, 32'd6,32'd2,32'd1};
    vecs[13] = '{1'b0,1'b1,1'b1,1'b1,64'h0000_0000_0000_00CC,64'h0000_0000_0000_00DD,5'd8, 1'b1,1'b0,1'b1,1'b1, 1'b0,64'h0,                 5'd0, 1'b0, 32'd6,32'd2,32'd1};
    vecs[14] = '{1'b1,1'b1,1'b0,1'b1,64'h0000_0000_0000_00EE,64'h0000_0000_0000_00FF,5'd9, 1'b1,1'b0,1'b1,1'b1, 1'b0,64'h0,                 5'd0, 1'b0, 32'd0,32'd0,32'd0};
    vecs[15] = '{1'b0,1'b0,1'b0,1'b1,64'h0000_0000_0000_0011,64'h0000_0000_0000_0022,5'd1, 1'b1,1'b0,1'b0,1'b0, 1'b1,64'h0000_0000_0000_0011,5'd1, 1'b1, 32'd1,32'd0,32'd0};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i]);
      @(posedge clock);
      #1;
      chk_beat($sformatf("v%0d", i), vecs[i].e_v, vecs[i].e_data, vecs[i].e_rd, vecs[i].e_rw);
      chk_perf($sformatf("v%0d", i), vecs[i].e_ret, vecs[i].e_ld, vecs[i].e_st);
    end

    // Outputs must not follow inputs between edges
    in_valid = 1'b0; rd = 5'd31; alu_result = 64'hFFFF_FFFF_FFFF_FFFF;
    read_data = 64'hFFFF_FFFF_FFFF_FFFF; MemtoReg = 1'b1; RegWrite = 1'b0;
    #3;
    chk_beat("nocomb", 1'b1, 64'h0000_0000_0000_0011, 5'd1, 1'b1);

    // Back-to-back beats alternating the data source
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; RegWrite = 1'b1; stall = 1'b0; flush = 1'b0; reset = 1'b0;
      alu_result = 64'h1000 + 64'(k); read_data = 64'h2000 + 64'(k);
      MemtoReg = k[0]; MemRead = k[0]; MemWrite = 1'b0; rd = 5'd10 + 5'(k);
      @(posedge clock);
      #1;
      chk_beat($sformatf("b2b%0d", k), 1'b1, (k % 2 == 1) ? 64'h2000 + 64'(k) : 64'h1000 + 64'(k),
               5'd10 + 5'(k), 1'b1);
    end
    chk_perf("b2b", 32'd5, 32'd2, 32'd0);

    // Reset wins over stall
    reset = 1'b1; stall = 1'b1;
    @(posedge clock);
    #1;
    chk_beat("rst_stall", 1'b0, 64'h0, 5'd0, 1'b0);
    chk_perf("rst_stall", 32'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_register.md
# mem_wb_register

Pipeline register and writeback select between the memory stage and the register file of the pipelined ARMv8 core. Each cycle it captures the memory-stage result (ALU result, load data, destination register, control bits) and presents one registered writeback beat: data, destination, write enable. It also drives the MEM/WB forwarding source for the execute-stage forwarding unit, and honours pipeline stall and flush from the hazard unit.

## Interface
Parameters:
- DATA_W, 64, datapath width
- REG_W, 5, register index width; index 31 is XZR

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- stall  in  1  hold all registered state this cycle
- flush  in  1  insert bubble this cycle
- in_valid  in  1  memory stage holds a real instruction
- alu_result  in  DATA_W  address or ALU value from the memory stage
- read_data  in  DATA_W  load data from data memory, valid in the same cycle as alu_result
- rd  in  REG_W  destination register
- RegWrite  in  1  instruction writes rd
- MemtoReg  in  1  1 = write read_data, 0 = write alu_result
- MemRead  in  1  instruction is a load
- MemWrite  in  1  instruction is a store
- wb_valid  out  1  registered beat is a real instruction
- wb_data  out  DATA_W  writeback value
- wb_rd  out  REG_W  writeback destination
- wb_RegWrite  out  1  register-file write enable, qualified
- fwd_en  out  1  forwarding source valid (= wb_RegWrite)
- fwd_rd  out  REG_W  forwarding destination (= wb_rd)
- fwd_data  out  DATA_W  forwarding value (= wb_data)

## Operation
- Next-state select: reset > flush > stall > capture.
- reset: every output and internal register is 0, counters included.
- flush (reset low): wb_valid, wb_RegWrite, fwd_en go to 0; wb_data and wb_rd go to 0. Flush overrides a simultaneous stall.
- stall (reset and flush low): all registers hold; counters do not advance.
- capture: wb_valid <= in_valid; wb_data <= MemtoReg ? read_data : alu_result; wb_rd <= rd; wb_RegWrite <= in_valid & RegWrite & (rd != 31).
- XZR rule: rd = 31 never asserts wb_RegWrite/fwd_en, but wb_data and wb_rd still capture their values.
- in_valid = 0: wb_RegWrite = 0 regardless of RegWrite; wb_data and wb_rd still capture their values.
- MemRead/MemWrite affect only the counters; MemtoReg alone selects the data source.
- Forwarding outputs are pure wires off the registered state; no combinational path from inputs to any output.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Throughput: one instruction per cycle when stall = 0.
- Stall held k cycles: outputs stay constant for k cycles; the input present on the first unstalled edge is captured.
- The register file writes at the same edge at which wb_* is sampled. Same-cycle read-after-write bypass is the register file's job, not this block's.

## Configuration
- MEM_WB_PERF_EN defined: adds outputs perf_retired, perf_loads, perf_stores, each 32 bits.
  - Updated on capture edges only (not on stall, flush or reset edges).
  - perf_retired increments when in_valid = 1.
  - perf_loads increments when in_valid & MemRead.
  - perf_stores increments when in_valid & MemWrite.
  - Wrap from 0xFFFFFFFF to 0. Reset to 0.
- MEM_WB_PERF_EN undefined: counters and ports absent; all other behaviour identical.

## Test plan
- Reset asserted 2 cycles with nonzero inputs -> all outputs 0 (and all counters 0 when MEM_WB_PERF_EN is defined).
- ALU op: in_valid=1, RegWrite=1, MemtoReg=0, alu_result=0x0000_0000_DEAD_BEEF, rd=9 -> next cycle wb_data=0xDEADBEEF, wb_rd=9, wb_RegWrite=1, fwd_en=1.
- Load: MemtoReg=1, MemRead=1, read_data=0x1234_5678_9ABC_DEF0, alu_result=0x40, rd=3 -> wb_data=0x123456789ABCDEF0, wb_rd=3; perf_loads=1 when MEM_WB_PERF_EN is defined.
- XZR write: rd=31, RegWrite=1, in_valid=1 -> wb_RegWrite=0, fwd_en=0, wb_valid=1.
- Stall 3 cycles after an ALU op to rd=5, while inputs change to rd=7 -> wb_rd=5 held for 3 cycles, then wb_rd=7 one cycle after stall drops.
- Flush and stall both asserted with in_valid=1, RegWrite=1 -> next cycle wb_valid=0, wb_RegWrite=0; counters unchanged.
